// File: rtl/uart_rx_if.sv
// Receive-side bundle: serial line in, byte stream out with valid/ready and status pulses.
interface uart_rx_if;
    logic       serial_in;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       rx_busy;

    modport master (
        input  serial_in,
        input  rx_ready,
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        output rx_busy
    );

    modport slave (
        output serial_in,
        output rx_ready,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        input  rx_busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling off a synchronized line, valid/ready output
// holding one byte, with frame-error and overrun pulses.
module uart_rx #(
    parameter int unsigned BAUD_DIV = 16
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.master bus
);

    localparam int unsigned CNT_W = 13;
    localparam int unsigned HALF  = BAUD_DIV / 2;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       idx, idx_next;
    logic [7:0]       shift, shift_next;
    logic [7:0]       data_next;
    logic             valid_next;
    logic             ferr_next;
    logic             ovr_next;
    logic             busy_next;
    logic             sync1, s_in, s_prev;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b1;
            s_in   <= 1'b1;
            s_prev <= 1'b1;
        end else begin
            sync1  <= bus.serial_in;
            s_in   <= sync1;
            s_prev <= s_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            idx           <= '0;
            shift         <= '0;
            bus.rx_data   <= '0;
            bus.rx_valid  <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.overrun   <= 1'b0;
            bus.rx_busy   <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            idx           <= idx_next;
            shift         <= shift_next;
            bus.rx_data   <= data_next;
            bus.rx_valid  <= valid_next;
            bus.frame_err <= ferr_next;
            bus.overrun   <= ovr_next;
            bus.rx_busy   <= busy_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        shift_next = shift;
        data_next  = bus.rx_data;
        valid_next = bus.rx_valid & ~bus.rx_ready;
        ferr_next  = 1'b0;
        ovr_next   = 1'b0;

        unique case (state)
            IDLE: begin
                if (s_prev && !s_in) begin
                    state_next = START;
                    cnt_next   = '0;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_next = '0;
                    idx_next = '0;
                    // A line already back high at mid start bit is a glitch
                    state_next = s_in ? IDLE : DATA;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_next   = '0;
                    shift_next = {s_in, shift[7:1]};
                    idx_next   = idx + 3'd1;
                    if (idx == 3'd7) begin
                        state_next = STOP;
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_next = '0;
                    if (s_in) begin
                        state_next = IDLE;
                        // Load when the slot is free or being emptied this very cycle
                        if (!bus.rx_valid || bus.rx_ready) begin
                            data_next  = shift;
                            valid_next = 1'b1;
                        end else begin
                            ovr_next = 1'b1;
                        end
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = WAIT_HIGH;
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            WAIT_HIGH: begin
                if (s_in) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter BAUD_DIV, default 16, clk cycles per serial bit; legal range 4..8191; HALF = BAUD_DIV/2 (integer division).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset; asynchronous, active-high; clock clk.
REQ-004 serial_in  input  1  asynchronous serial line, idle high.
REQ-005 rx_ready  input  1  consumer accepts rx_data when high with rx_valid.
REQ-006 rx_data  output  8  last accepted byte, stable while rx_valid=1.
REQ-007 rx_valid  output  1  byte available; held until handshake.
REQ-008 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 overrun  output  1  one-cycle pulse: good frame completed while rx_valid=1 and rx_ready=0.
REQ-010 rx_busy  output  1  high in any state other than IDLE.

Function
REQ-011 Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), BAUD_DIV clocks per bit.
REQ-012 serial_in passes through a 2-flop synchronizer (reset value 1); the FSM uses only the synchronized value s_in and its 1-cycle delayed copy s_prev (reset value 1).
REQ-013 FSM states: IDLE, START, DATA, STOP, WAIT_HIGH; width-13 baud counter; 3-bit bit index.
REQ-014 IDLE: on s_prev=1 and s_in=0 (edge cycle E), go to START and clear the baud counter.
REQ-015 START: sample s_in at cycle E+HALF; if 1 (glitch), return to IDLE with no output activity; if 0, go to DATA.
REQ-016 DATA: bit i (i=0..7) sampled at E+HALF+(i+1)*BAUD_DIV and shifted in LSB-first; after bit 7, go to STOP.
REQ-017 STOP: sample at E+HALF+9*BAUD_DIV (mid stop bit); the FSM leaves STOP in that same sample cycle, and the next start edge is accepted on the following cycle.
REQ-018 Stop sampled 1 and rx_valid=0, or rx_valid=1 with rx_ready=1 in that cycle: load rx_data and hold rx_valid=1 from the next clock edge; go to IDLE.
REQ-019 Stop sampled 1, rx_valid=1 and rx_ready=0: discard the new byte, keep rx_data unchanged, pulse overrun for 1 cycle; go to IDLE.
REQ-020 Stop sampled 0: discard the byte, pulse frame_err for 1 cycle, go to WAIT_HIGH; rx_valid and rx_data are unaffected.
REQ-021 WAIT_HIGH: stay until s_in=1, then go to IDLE; no start edge is detected while in WAIT_HIGH (break handling).
REQ-022 Handshake: rx_valid=1 and rx_ready=1 on a clock edge clears rx_valid, unless REQ-018 reloads in the same cycle, in which case rx_valid stays 1 with the new byte.
REQ-023 rx_ready is ignored while rx_valid=0; rx_data holds its last value after handshake.
REQ-024 Latency: serial_in falling edge to edge cycle E = 2-3 clk; rx_valid rises 1 clk after the stop sample.
REQ-025 The block accepts back-to-back frames from a transmitter using the same BAUD_DIV with zero idle gap, with no loss while the consumer keeps rx_ready=1.

Reset
REQ-026 During rst the reset values are: rx_data=0x00, rx_valid=0, frame_err=0, overrun=0, rx_busy=0, FSM=IDLE, counters=0, synchronizer flops and s_prev=1.
REQ-027 rst asserted mid-frame aborts the frame without emitting any data, frame_err or overrun; after release, the next valid falling edge starts a fresh frame.

Verification (BAUD_DIV=16, ideal line, rx_ready=1 unless stated)
REQ-028 Send 0xA5 -> rx_valid high one cycle after the stop sample, rx_data=0xA5, frame_err=0, overrun=0; rx_valid clears the cycle after the handshake.
REQ-029 Drive serial_in low for 4 clk, then high -> START rejects the glitch, rx_busy returns to 0, no rx_valid or frame_err.
REQ-030 Send 0x3C with the stop bit forced 0 for 16 clk, line then held low 40 clk -> one frame_err pulse, rx_valid stays 0, FSM stays in WAIT_HIGH until the line rises, then receives a subsequent 0x5A correctly.
REQ-031 With rx_ready=0, send 0x11 then 0x22 -> rx_data=0x11 with rx_valid held, one overrun pulse at the 0x22 stop sample; raising rx_ready then gives one handshake of 0x11.
REQ-032 Assert rst after data bit 3 of a frame -> all outputs equal REQ-026 values; the following 0x7E is received correctly.
REQ-033 Loopback a transmitter with BAUD_DIV=16 sending 0x00, 0xFF, 0x80 back-to-back -> three rx_valid handshakes in order, no errors.
